// File: rtl/adder_serial_n_bit.sv
// Digit-serial N-bit adder/subtractor, one D-bit digit per clock, LSB first.
// Start/busy/done handshake; results are registered and change only on completion.
module adder_serial_n_bit #(
    parameter int N = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if (D < 1 || D > N || (N % D) != 0) begin : g_bad_param
            $error("adder_serial_n_bit: need 1 <= D <= N and N %% D == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  x_q;
    logic [N-1:0]  y_q;
    logic [N-1:0]  acc;
    logic          carry_q;
    logic [CW-1:0] cnt;

    logic [D:0]    dig;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  x_nxt;
    logic [N-1:0]  y_nxt;
    logic          ovf_nxt;

    // Add the current low digit of both operand shift registers plus running carry
    always_comb begin
        dig = {1'b0, x_q[D-1:0]} + {1'b0, y_q[D-1:0]} + {{D{1'b0}}, carry_q};
    end

    // On the last digit x_q/y_q hold the top digit, so their MSBs are the
    // operand sign bits and dig[D-1] is the result sign bit.
    always_comb begin
        ovf_nxt = (x_q[D-1] == y_q[D-1]) && (dig[D-1] != x_q[D-1]);
    end

    generate
        if (K == 1) begin : g_single
            assign acc_nxt = dig[D-1:0];
            assign x_nxt   = '0;
            assign y_nxt   = '0;
        end else begin : g_multi
            assign acc_nxt = {dig[D-1:0], acc[N-1:D]};
            assign x_nxt   = {{D{1'b0}}, x_q[N-1:D]};
            assign y_nxt   = {{D{1'b0}}, y_q[N-1:D]};
        end
    endgenerate

    // Control FSM, operand/result shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y ^ {N{sub}};
                        carry_q <= c_in ^ sub;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    acc     <= acc_nxt;
                    x_q     <= x_nxt;
                    y_q     <= y_nxt;
                    carry_q <= dig[D];
                    if (cnt == LAST) begin
                        sum   <= acc_nxt;
                        c_out <= dig[D];
                        ovf   <= ovf_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_serial_n_bit.sv
// Testbench for adder_serial_n_bit: directed tests on N=8/D=2 plus a
// parameter sweep over several (N,D) instances, scoreboard-based.
module tb_adder_serial_n_bit;

    localparam int NI = 5;
    localparam int NS [NI] = '{8, 8, 8, 16, 32};
    localparam int DS [NI] = '{2, 1, 8, 4, 2};

    typedef struct {
        int          g;
        logic [31:0] sum;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sbq[$];

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [31:0] s_x   [NI];
    logic [31:0] s_y   [NI];
    logic [31:0] s_sum [NI];
    logic        s_start [NI];
    logic        s_sub   [NI];
    logic        s_cin   [NI];
    logic        s_busy  [NI];
    logic        s_done  [NI];
    logic        s_cout  [NI];
    logic        s_ovf   [NI];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt [NI];
    int overlap_cnt [NI];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int N = NS[g];
            localparam int D = DS[g];
            logic [N-1:0] sum_w;
            assign s_sum[g] = 32'(sum_w);
            adder_serial_n_bit #(.N(N), .D(D)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (s_start[g]),
                .sub   (s_sub[g]),
                .x     (s_x[g][N-1:0]),
                .y     (s_y[g][N-1:0]),
                .c_in  (s_cin[g]),
                .busy  (s_busy[g]),
                .done  (s_done[g]),
                .sum   (sum_w),
                .c_out (s_cout[g]),
                .ovf   (s_ovf[g])
            );
        end
    endgenerate

    // Cycle counter, done pulse counter and busy/done overlap monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < NI; g++) begin
            if (s_done[g] === 1'b1) done_cnt[g] <= done_cnt[g] + 1;
            if (s_done[g] === 1'b1 && s_busy[g] === 1'b1)
                overlap_cnt[g] <= overlap_cnt[g] + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(int g, logic [31:0] a, logic [31:0] b,
                                   logic s, logic ci);
        exp_t e;
        longint unsigned mask;
        longint unsigned xa;
        longint unsigned ye;
        longint unsigned full;
        mask = (64'd1 << NS[g]) - 64'd1;
        xa   = {32'd0, a} & mask;
        ye   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        full = xa + ye + 64'(ci ^ s);
        e.g   = g;
        e.sum = 32'(full & mask);
        e.c   = full[NS[g]];
        e.v   = (xa[NS[g]-1] == ye[NS[g]-1]) && (e.sum[NS[g]-1] != xa[NS[g]-1]);
        return e;
    endfunction

    function automatic exp_t mk(int g, logic [31:0] s, logic c, logic v);
        exp_t e;
        e.g = g;
        e.sum = s;
        e.c = c;
        e.v = v;
        return e;
    endfunction

    // Drive one start pulse at a negedge; returns at the following negedge
    task automatic issue(int g, logic [31:0] a, logic [31:0] b,
                         logic s, logic ci);
        s_x[g] = a;
        s_y[g] = b;
        s_sub[g] = s;
        s_cin[g] = ci;
        s_start[g] = 1'b1;
        @(negedge clk);
        s_start[g] = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < NI; g++) begin
            s_start[g] = 1'b0;
            s_sub[g] = 1'b0;
            s_cin[g] = 1'b0;
            s_x[g] = '0;
            s_y[g] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if ({s_busy[g], s_done[g], s_cout[g], s_ovf[g]} !== 4'b0000 ||
                s_sum[g] !== 32'd0) begin
                errors++;
                $display("FAIL reset%0d: busy=%b done=%b sum=%h c=%b v=%b want all 0",
                         g, s_busy[g], s_done[g], s_sum[g], s_cout[g], s_ovf[g]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [7:0] ta [10];
        logic [7:0] tb [10];
        logic       ts [10];
        logic       tc [10];
        logic [7:0] es [10];
        logic       ec [10];
        logic       ev [10];
        exp_t e;
        int lat;
        ta = '{8'h00, 8'h01, 8'h55, 8'h07, 8'h03, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10};
        tb = '{8'h00, 8'h01, 8'hAA, 8'hF1, 8'hF6, 8'h01, 8'h01, 8'h07, 8'h01, 8'h10};
        ts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        es = '{8'h00, 8'h02, 8'hFF, 8'hF8, 8'hFA, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00};
        ec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            sbq.push_back(mk(0, 32'(es[i]), ec[i], ev[i]));
            issue(0, 32'(ta[i]), 32'(tb[i]), ts[i], tc[i]);
            checks++;
            if (s_busy[0] !== 1'b1 || s_done[0] !== 1'b0) begin
                errors++;
                $display("FAIL arith%0d_busy: busy=%b done=%b want 1 0",
                         i, s_busy[0], s_done[0]);
            end
            lat = 0;
            while (s_done[0] !== 1'b1 && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            e = sbq.pop_front();
            checks++;
            if (s_done[0] !== 1'b1 || lat != 4) begin
                errors++;
                $display("FAIL arith%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if (s_sum[0] !== e.sum || s_cout[0] !== e.c || s_ovf[0] !== e.v) begin
                errors++;
                $display("FAIL arith%0d_result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                         i, s_sum[0], s_cout[0], s_ovf[0], e.sum, e.c, e.v);
            end
            @(negedge clk);
            checks++;
            if (s_done[0] !== 1'b0 || s_busy[0] !== 1'b0 || s_sum[0] !== e.sum) begin
                errors++;
                $display("FAIL arith%0d_pulse: done=%b busy=%b sum=%h want 0 0 %h",
                         i, s_done[0], s_busy[0], s_sum[0], e.sum);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] b [3];
        int t [3];
        int lat;
        exp_t e;
        a = '{32'h12, 32'hC4, 32'h7F};
        b = '{32'h9A, 32'h3C, 32'h7F};
        s_x[0] = a[0];
        s_y[0] = b[0];
        s_sub[0] = 1'b0;
        s_cin[0] = 1'b0;
        s_start[0] = 1'b1;
        sbq.push_back(model(0, a[0], b[0], 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (s_busy[0] !== 1'b1 || s_done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b%0d_restart: busy=%b done=%b want 1 0",
                             k, s_busy[0], s_done[0]);
                end
            end
            lat = 1;
            while (s_done[0] !== 1'b1 && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            t[k] = cyc;
            e = sbq.pop_front();
            checks++;
            if (s_done[0] !== 1'b1 || s_sum[0] !== e.sum || s_cout[0] !== e.c ||
                s_ovf[0] !== e.v) begin
                errors++;
                $display("FAIL b2b%0d_result: got done=%b sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                         k, s_done[0], s_sum[0], s_cout[0], s_ovf[0], e.sum, e.c, e.v);
            end
            if (k < 2) begin
                s_x[0] = a[k+1];
                s_y[0] = b[k+1];
                s_sub[0] = 1'(k);
                sbq.push_back(model(0, a[k+1], b[k+1], 1'(k), 1'b0));
            end else begin
                s_start[0] = 1'b0;
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t[k] - t[k-1] != 5) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d want 5", k, t[k] - t[k-1]);
            end
        end
        @(negedge clk);
        checks++;
        if (s_busy[0] !== 1'b0 || s_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", s_busy[0], s_done[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int base;
        int lat;
        exp_t e;
        base = done_cnt[0];
        sbq.push_back(model(0, 32'h21, 32'h43, 1'b0, 1'b1));
        issue(0, 32'h21, 32'h43, 1'b0, 1'b1);
        s_x[0] = 32'hFF;
        s_y[0] = 32'hFF;
        s_start[0] = 1'b1;
        repeat (3) @(negedge clk);
        s_start[0] = 1'b0;
        lat = 0;
        while (s_done[0] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sbq.pop_front();
        checks++;
        if (s_done[0] !== 1'b1 || s_sum[0] !== e.sum || s_cout[0] !== e.c) begin
            errors++;
            $display("FAIL ignore_result: got done=%b sum=%h c=%b want sum=%h c=%b",
                     s_done[0], s_sum[0], s_cout[0], e.sum, e.c);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt[0] - base != 1 || s_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d done pulses busy=%b want 1 0",
                     done_cnt[0] - base, s_busy[0]);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        exp_t e;
        sbq.push_back(model(0, 32'h3C, 32'h4B, 1'b1, 1'b1));
        issue(0, 32'h3C, 32'h4B, 1'b1, 1'b1);
        lat = 0;
        while (s_done[0] !== 1'b1 && lat < 64) begin
            s_x[0] = $urandom;
            s_y[0] = $urandom;
            s_sub[0] = 1'($urandom_range(0, 1));
            s_cin[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        e = sbq.pop_front();
        checks++;
        if (s_done[0] !== 1'b1 || s_sum[0] !== e.sum || s_cout[0] !== e.c ||
            s_ovf[0] !== e.v) begin
            errors++;
            $display("FAIL opchange_result: got done=%b sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                     s_done[0], s_sum[0], s_cout[0], s_ovf[0], e.sum, e.c, e.v);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat;
        int base;
        logic seen;
        exp_t e;
        sbq.push_back(model(0, 32'h80, 32'hC0, 1'b0, 1'b0));
        issue(0, 32'h80, 32'hC0, 1'b0, 1'b0);
        lat = 0;
        while (s_done[0] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        e = sbq.pop_front();
        checks++;
        if (s_sum[0] !== e.sum || s_cout[0] !== e.c || s_ovf[0] !== e.v) begin
            errors++;
            $display("FAIL abort_pre: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                     s_sum[0], s_cout[0], s_ovf[0], e.sum, e.c, e.v);
        end
        @(negedge clk);
        issue(0, 32'h11, 32'h22, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s_busy[0] !== 1'b0 || s_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_ctrl: busy=%b done=%b want 0 0", s_busy[0], s_done[0]);
        end
        checks++;
        if (s_sum[0] !== 32'd0 || s_cout[0] !== 1'b0 || s_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_outs: sum=%h c=%b v=%b want 0 0 0",
                     s_sum[0], s_cout[0], s_ovf[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt[0];
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | s_busy[0] | s_done[0];
        end
        checks++;
        if (seen !== 1'b0 || done_cnt[0] != base) begin
            errors++;
            $display("FAIL abort_idle: activity=%b extra_done=%0d want 0 0",
                     seen, done_cnt[0] - base);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        logic ci;
        int lat;
        int k;
        exp_t e;
        for (int g = 1; g < NI; g++) begin
            k = NS[g] / DS[g];
            for (int i = 0; i < 12; i++) begin
                a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
                b = (i == 0) ? 32'd1 : $urandom;
                s = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                ci = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                sbq.push_back(model(g, a, b, s, ci));
                issue(g, a, b, s, ci);
                lat = 0;
                while (s_done[g] !== 1'b1 && lat < 64) begin
                    @(negedge clk);
                    lat++;
                end
                e = sbq.pop_front();
                checks++;
                if (s_done[g] !== 1'b1 || lat != k) begin
                    errors++;
                    $display("FAIL sweep_n%0d_d%0d_lat%0d: got %0d want %0d",
                             NS[g], DS[g], i, lat, k);
                end
                checks++;
                if (s_sum[g] !== e.sum || s_cout[g] !== e.c || s_ovf[g] !== e.v) begin
                    errors++;
                    $display("FAIL sweep_n%0d_d%0d_res%0d: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                             NS[g], DS[g], i, s_sum[g], s_cout[g], s_ovf[g], e.sum, e.c, e.v);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_start_ignored();
        test_operand_change();
        test_reset_abort();
        test_sweep();
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (overlap_cnt[g] != 0) begin
                errors++;
                $display("FAIL overlap%0d: busy&done cycles got %0d want 0",
                         g, overlap_cnt[g]);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
